quicksort_exerciser: RTL and testbench
======================================

Name: quicksort_exerciser

Overview:
- Synthesizable initiator for the quicksort sorter interface. It drives `array_in`, `enable`, `hi_ind` and `lo_ind`, waits for `array_valid`, checks `sorted_array`, and drops `enable` between vectors.
- Exhaustively enumerates every input vector, counts passes, fails and timeouts, and captures the first failing vector.
- Sits beside the sorter on the FPGA for on-board self-test and as a reusable stimulus engine.

Parameters:
- ARR_WIDTH, 4: number of array elements.
- ELEM_BITS, 4: bits per element field.
- VAL_BITS, 3: enumerated value bits per element (values 0..2^VAL_BITS-1); VAL_BITS <= ELEM_BITS.
- GAP_CYCLES, 2: minimum `enable`-low cycles between vectors.
- TIMEOUT, 1024: max cycles waiting for `array_valid`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `array_out` out ARR_WIDTH*ELEM_BITS: to sorter `array_in`; element 0 in the MSB field.
- `enable_out` out 1: to sorter `enable`.
- `hi_ind` out 4: constant ARR_WIDTH-1.
- `lo_ind` out 4: constant 0.
- `array_valid_in` in 1: from sorter `array_valid`.
- `sorted_array_in` in ARR_WIDTH*ELEM_BITS: from sorter `sorted_array`.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held high.
- `pass_count` out 32: vectors passing.
- `fail_count` out 32: vectors failing, timeouts included.
- `timeout_count` out 32: vectors with no `array_valid`.
- `first_fail` out ARR_WIDTH*ELEM_BITS: input vector of the first failure.
- `first_fail_valid` out 1: `first_fail` is meaningful.

Behaviour:
- Reset (`reset`=0 at a clock edge): state IDLE.
  - All outputs 0 except `hi_ind`=ARR_WIDTH-1.
  - Vector counter 0. Applies mid-run too; the run is abandoned.
- Vector counter: ARR_WIDTH*VAL_BITS bits.
  - Digit k (VAL_BITS bits, digit 0 least significant) drives element ARR_WIDTH-1-k, zero-extended to ELEM_BITS.
  - Total vectors N = 2^(ARR_WIDTH*VAL_BITS); 4096 at defaults.
- IDLE: `start`=1 -> clear counters, `first_fail_valid`, vector counter; go to DRIVE. `busy`=1 from the next cycle.
- DRIVE:
  - `enable_out`=1; `array_out` holds the current vector and is stable for the whole state.
  - Timeout counter increments each cycle.
  - `array_valid_in`=1 -> latch `sorted_array_in`, go to CHECK.
  - Timeout counter reaches TIMEOUT-1 with no valid -> fail++ and timeout++; capture `first_fail` if `first_fail_valid`=0; go to GAP.
- CHECK (1 cycle, `enable_out`=0). Pass iff both hold:
  - sorted: element i <= element i+1 for all i, unsigned, element 0 at MSB;
  - element sum of the latched output equals the element sum of the input (sum width ELEM_BITS+clog2(ARR_WIDTH)).
  - Pass -> pass++. Otherwise fail++ and capture `first_fail` if not yet valid. Go to GAP.
- GAP: `enable_out`=0. Exit only after at least GAP_CYCLES cycles in GAP and when `array_valid_in`=0.
  - Last vector -> DONE.
  - Otherwise vector counter +1 -> DRIVE.
- DONE: `busy`=0, `done`=1; counters hold. `start`=1 -> clear everything, `done`=0, begin a new run in DRIVE.
- `start` while busy is ignored.
- Counters saturate at 2^32-1.
- Invariant at DONE: `pass_count` + `fail_count` = N.

Test Plan:
- Reset check: hold `reset`=0 for 3 cycles -> `enable_out`=0, `busy`=0, `done`=0, all counts 0, `hi_ind`=3, `lo_ind`=0.
- Correct behavioural sorter with 3-cycle latency, defaults:
  - `start` pulse -> `busy`=1 next cycle;
  - `enable_out` held through each handshake and low for at least 2 cycles between vectors;
  - DONE with `pass_count`=4096, `fail_count`=0, `first_fail_valid`=0.
- Pass-through model (output = input):
  - `pass_count`=330 (nondecreasing 4-tuples over 0..7), `fail_count`=3766;
  - `first_fail`=16'h0010.
- All-zero output model: `pass_count`=1 (vector 0 only), `fail_count`=4095, `first_fail`=16'h0001 (sum mismatch).
- Silent model (never valid), VAL_BITS=1, TIMEOUT=16:
  - `timeout_count`=16, `fail_count`=16, `pass_count`=0;
  - each DRIVE lasts exactly 16 cycles.
- Control corners, correct model:
  - `start` pulse mid-run -> ignored;
  - `reset`=0 mid-run -> IDLE with counters 0;
  - restart from DONE -> counters cleared, second run again gives `pass_count`=4096.

Source files
------------

// File: rtl/quicksort_exerciser_if.sv
// Handshake bundle between the quicksort exerciser and a sorter.
interface quicksort_exerciser_if #(
    parameter int ARR_WIDTH = 4,
    parameter int ELEM_BITS = 4
);
    logic [ARR_WIDTH*ELEM_BITS-1:0] array_out;
    logic                           enable_out;
    logic [3:0]                     hi_ind;
    logic [3:0]                     lo_ind;
    logic                           array_valid_in;
    logic [ARR_WIDTH*ELEM_BITS-1:0] sorted_array_in;

    modport master (
        output array_out, enable_out, hi_ind, lo_ind,
        input  array_valid_in, sorted_array_in
    );

    modport slave (
        input  array_out, enable_out, hi_ind, lo_ind,
        output array_valid_in, sorted_array_in
    );
endinterface

// File: rtl/quicksort_exerciser.sv
// Exhaustive stimulus engine and checker for a quicksort sorter.
module quicksort_exerciser #(
    parameter int ARR_WIDTH  = 4,
    parameter int ELEM_BITS  = 4,
    parameter int VAL_BITS   = 3,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    quicksort_exerciser_if.master          bus,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    pass_count,
    output logic [31:0]                    fail_count,
    output logic [31:0]                    timeout_count,
    output logic [ARR_WIDTH*ELEM_BITS-1:0] first_fail,
    output logic                           first_fail_valid
);
    localparam int AW = ARR_WIDTH * ELEM_BITS;
    localparam int VW = ARR_WIDTH * VAL_BITS;
    localparam int SW = ELEM_BITS + $clog2(ARR_WIDTH);

    typedef enum logic [2:0] {IDLE, DRIVE, CHECK, GAP, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [VW-1:0] vec;
    logic [AW-1:0] vec_arr;
    logic [AW-1:0] result;
    logic [31:0]   tick;
    logic          clear;
    logic          latch;
    logic          pass_inc;
    logic          fail_inc;
    logic          to_inc;
    logic          vec_inc;
    logic          in_order;
    logic [SW-1:0] sum_in;
    logic [SW-1:0] sum_out;

    always_comb begin
        vec_arr = '0;
        for (int k = 0; k < ARR_WIDTH; k++)
            vec_arr[k*ELEM_BITS +: ELEM_BITS] =
                ELEM_BITS'(vec[k*VAL_BITS +: VAL_BITS]);
    end

    // Element 0 lives in the top field, so field f+1 precedes field f.
    always_comb begin
        in_order = 1'b1;
        sum_in   = '0;
        sum_out  = '0;
        for (int i = 0; i < ARR_WIDTH; i++) begin
            sum_in  = sum_in + SW'(vec_arr[i*ELEM_BITS +: ELEM_BITS]);
            sum_out = sum_out + SW'(result[i*ELEM_BITS +: ELEM_BITS]);
        end
        for (int i = 0; i + 1 < ARR_WIDTH; i++)
            if (result[(i+1)*ELEM_BITS +: ELEM_BITS] >
                result[i*ELEM_BITS +: ELEM_BITS])
                in_order = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        latch      = 1'b0;
        pass_inc   = 1'b0;
        fail_inc   = 1'b0;
        to_inc     = 1'b0;
        vec_inc    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (bus.array_valid_in) begin
                    latch      = 1'b1;
                    state_next = CHECK;
                end else if (tick == 32'(TIMEOUT - 1)) begin
                    fail_inc   = 1'b1;
                    to_inc     = 1'b1;
                    state_next = GAP;
                end
            end
            CHECK: begin
                if (in_order && sum_in == sum_out)
                    pass_inc = 1'b1;
                else
                    fail_inc = 1'b1;
                state_next = GAP;
            end
            GAP: begin
                if (tick + 32'd1 >= 32'(GAP_CYCLES) && !bus.array_valid_in) begin
                    if (&vec) begin
                        state_next = DONE;
                    end else begin
                        vec_inc    = 1'b1;
                        state_next = DRIVE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vec              <= '0;
            result           <= '0;
            tick             <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            timeout_count    <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            // tick measures time spent in the current state
            if (state_next != state)
                tick <= '0;
            else if (tick != '1)
                tick <= tick + 32'd1;
            if (clear) begin
                vec              <= '0;
                pass_count       <= '0;
                fail_count       <= '0;
                timeout_count    <= '0;
                first_fail       <= '0;
                first_fail_valid <= 1'b0;
            end
            if (latch)
                result <= bus.sorted_array_in;
            if (vec_inc)
                vec <= vec + 1'b1;
            if (pass_inc && pass_count != '1)
                pass_count <= pass_count + 32'd1;
            if (fail_inc && fail_count != '1)
                fail_count <= fail_count + 32'd1;
            if (to_inc && timeout_count != '1)
                timeout_count <= timeout_count + 32'd1;
            if (fail_inc && !first_fail_valid) begin
                first_fail       <= vec_arr;
                first_fail_valid <= 1'b1;
            end
        end
    end

    assign bus.enable_out = (state == DRIVE);
    assign bus.array_out  = vec_arr;
    assign bus.hi_ind     = 4'(ARR_WIDTH - 1);
    assign bus.lo_ind     = 4'd0;
    assign busy           = (state == DRIVE) || (state == CHECK) || (state == GAP);
    assign done           = (state == DONE);
endmodule

// File: tb/tb_quicksort_exerciser.sv
// Bench for quicksort_exerciser: table of sorter models, random faults,
// silent sorter timeouts and control corners.
module tb_quicksort_exerciser;
    localparam int N = 4096;

    logic clock = 1'b0;
    logic reset_m = 1'b0;
    logic reset_r = 1'b0;
    logic reset_s = 1'b0;
    logic start_m = 1'b0;
    logic start_r = 1'b0;
    logic start_s = 1'b0;

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    quicksort_exerciser_if #(.ARR_WIDTH(4), .ELEM_BITS(4)) bus_m ();
    quicksort_exerciser_if #(.ARR_WIDTH(4), .ELEM_BITS(4)) bus_r ();
    quicksort_exerciser_if #(.ARR_WIDTH(4), .ELEM_BITS(4)) bus_s ();

    logic        busy_m, done_m, ffv_m;
    logic [31:0] pass_m, fail_m, to_m;
    logic [15:0] ff_m;
    logic        busy_r, done_r, ffv_r;
    logic [31:0] pass_r, fail_r, to_r;
    logic [15:0] ff_r;
    logic        busy_s, done_s, ffv_s;
    logic [31:0] pass_s, fail_s, to_s;
    logic [15:0] ff_s;

    quicksort_exerciser dut_m (
        .clock(clock), .reset(reset_m), .start(start_m), .bus(bus_m),
        .busy(busy_m), .done(done_m), .pass_count(pass_m),
        .fail_count(fail_m), .timeout_count(to_m),
        .first_fail(ff_m), .first_fail_valid(ffv_m)
    );

    quicksort_exerciser dut_r (
        .clock(clock), .reset(reset_r), .start(start_r), .bus(bus_r),
        .busy(busy_r), .done(done_r), .pass_count(pass_r),
        .fail_count(fail_r), .timeout_count(to_r),
        .first_fail(ff_r), .first_fail_valid(ffv_r)
    );

    quicksort_exerciser #(.VAL_BITS(1), .TIMEOUT(16)) dut_s (
        .clock(clock), .reset(reset_s), .start(start_s), .bus(bus_s),
        .busy(busy_s), .done(done_s), .pass_count(pass_s),
        .fail_count(fail_s), .timeout_count(to_s),
        .first_fail(ff_s), .first_fail_valid(ffv_s)
    );

    function automatic logic [15:0] sort4(input logic [15:0] a);
        logic [3:0] e [4];
        logic [3:0] t;
        for (int i = 0; i < 4; i++) e[i] = a[(3-i)*4 +: 4];
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                if (e[i] > e[i+1]) begin
                    t = e[i]; e[i] = e[i+1]; e[i+1] = t;
                end
        return {e[0], e[1], e[2], e[3]};
    endfunction

    function automatic bit nondecr(input logic [15:0] a);
        return a[15:12] <= a[11:8] && a[11:8] <= a[7:4] && a[7:4] <= a[3:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // main sorter model: 0 correct, 1 pass-through, 2 all-zero
    int mode_m = 0;
    int lat_m = 3;
    int hi_m = 0;
    always @(posedge clock) hi_m <= bus_m.enable_out ? hi_m + 1 : 0;
    always_comb begin
        bus_m.array_valid_in = bus_m.enable_out && (hi_m >= lat_m);
        case (mode_m)
            0: bus_m.sorted_array_in = sort4(bus_m.array_out);
            1: bus_m.sorted_array_in = bus_m.array_out;
            default: bus_m.sorted_array_in = 16'h0;
        endcase
    end

    // random sorter: per-vector latency and fault kind (6 echo, 7 bump)
    int lat_tab [N];
    int flt_tab [N];
    int hi_r = 0;
    logic [11:0] idx_r;
    logic [15:0] srt_r;
    always @(posedge clock) hi_r <= bus_r.enable_out ? hi_r + 1 : 0;
    always_comb begin
        idx_r = {bus_r.array_out[14:12], bus_r.array_out[10:8],
                 bus_r.array_out[6:4], bus_r.array_out[2:0]};
        srt_r = sort4(bus_r.array_out);
        bus_r.array_valid_in = bus_r.enable_out && (hi_r >= lat_tab[idx_r]);
        case (flt_tab[idx_r])
            6: bus_r.sorted_array_in = bus_r.array_out;
            7: bus_r.sorted_array_in = srt_r + 16'd1;
            default: bus_r.sorted_array_in = srt_r;
        endcase
    end

    assign bus_s.array_valid_in  = 1'b0;
    assign bus_s.sorted_array_in = 16'h0;

    // protocol monitor on the main sorter link
    int   viol_m = 0;
    int   vecs_m = 0;
    int   low_m = 100;
    bit   strict_m = 1'b1;
    logic pen_m = 1'b0;
    logic pval_m = 1'b0;
    logic [15:0] parr_m = 16'h0;
    always @(negedge clock) begin
        if (bus_m.enable_out) begin
            if (!pen_m) begin
                vecs_m <= vecs_m + 1;
                if (low_m < 2) viol_m <= viol_m + 1;
            end else if (bus_m.array_out != parr_m) begin
                viol_m <= viol_m + 1;
            end
            low_m <= 0;
        end else begin
            if (pen_m && !pval_m && strict_m) viol_m <= viol_m + 1;
            low_m <= low_m + 1;
        end
        pen_m  <= bus_m.enable_out;
        pval_m <= bus_m.array_valid_in;
        parr_m <= bus_m.array_out;
    end

    // DRIVE length monitor on the silent link
    int run_s = 0;
    int min_s = 1000;
    int max_s = 0;
    int drv_s = 0;
    always @(negedge clock) begin
        if (bus_s.enable_out) begin
            run_s <= run_s + 1;
        end else begin
            if (run_s != 0) begin
                min_s <= (run_s < min_s) ? run_s : min_s;
                max_s <= (run_s > max_s) ? run_s : max_s;
                drv_s <= drv_s + 1;
            end
            run_s <= 0;
        end
    end

    typedef struct {
        int          mode;
        int          lat;
        logic [31:0] pass;
        logic [31:0] fail;
        logic [15:0] ff;
        logic        ffv;
    } rec_t;

    rec_t        tbl [3];
    int          exp_pass_r;
    bit          exp_ffv_r;
    logic [15:0] exp_ff_r;

    task automatic run_main_table();
        int base_v;
        int base_x;
        for (int i = 0; i < 3; i++) begin
            mode_m = tbl[i].mode;
            lat_m  = tbl[i].lat;
            base_v = vecs_m;
            base_x = viol_m;
            @(posedge clock); #1 start_m = 1'b1;
            @(posedge clock); #1 start_m = 1'b0;
            check($sformatf("busy_after_start[%0d]", i), busy_m, 1);
            if (i == 0) begin
                repeat (500) @(posedge clock);
                #1 start_m = 1'b1;
                @(posedge clock); #1 start_m = 1'b0;
                check("busy_after_ignored_start", busy_m, 1);
            end
            for (int c = 0; c < 40000 && !done_m; c++) @(posedge clock);
            #1;
            check($sformatf("done[%0d]", i), done_m, 1);
            check($sformatf("busy_at_done[%0d]", i), busy_m, 0);
            check($sformatf("pass[%0d]", i), pass_m, tbl[i].pass);
            check($sformatf("fail[%0d]", i), fail_m, tbl[i].fail);
            check($sformatf("timeouts[%0d]", i), to_m, 0);
            check($sformatf("first_fail_valid[%0d]", i), ffv_m, tbl[i].ffv);
            check($sformatf("first_fail[%0d]", i), ff_m, tbl[i].ff);
            check($sformatf("vectors[%0d]", i), vecs_m - base_v, N);
            check($sformatf("protocol[%0d]", i), viol_m - base_x, 0);
        end
    endtask

    task automatic run_main_corners();
        mode_m = 0;
        lat_m  = 0;
        @(posedge clock); #1 start_m = 1'b1;
        @(posedge clock); #1 start_m = 1'b0;
        check("restart_done_low", done_m, 0);
        check("restart_busy", busy_m, 1);
        check("restart_pass_clear", pass_m, 0);
        check("restart_fail_clear", fail_m, 0);
        check("restart_ffv_clear", ffv_m, 0);
        repeat (300) @(posedge clock);
        #1 strict_m = 1'b0;
        reset_m = 1'b0;
        @(posedge clock); #1 reset_m = 1'b1;
        check("midreset_busy", busy_m, 0);
        check("midreset_done", done_m, 0);
        check("midreset_enable", bus_m.enable_out, 0);
        check("midreset_pass", pass_m, 0);
        repeat (3) @(posedge clock);
        #1 strict_m = 1'b1;
        @(posedge clock); #1 start_m = 1'b1;
        @(posedge clock); #1 start_m = 1'b0;
        for (int c = 0; c < 40000 && !done_m; c++) @(posedge clock);
        #1;
        check("rerun_done", done_m, 1);
        check("rerun_pass", pass_m, N);
        check("rerun_fail", fail_m, 0);
    endtask

    task automatic run_random();
        @(posedge clock); #1 start_r = 1'b1;
        @(posedge clock); #1 start_r = 1'b0;
        for (int c = 0; c < 40000 && !done_r; c++) @(posedge clock);
        #1;
        check("rand_done", done_r, 1);
        check("rand_pass", pass_r, exp_pass_r);
        check("rand_fail", fail_r, N - exp_pass_r);
        check("rand_sum", pass_r + fail_r, N);
        check("rand_timeouts", to_r, 0);
        check("rand_ffv", ffv_r, exp_ffv_r);
        check("rand_first_fail", ff_r, exp_ff_r);
    endtask

    task automatic run_silent();
        @(posedge clock); #1 start_s = 1'b1;
        @(posedge clock); #1 start_s = 1'b0;
        for (int c = 0; c < 2000 && !done_s; c++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        check("silent_done", done_s, 1);
        check("silent_timeouts", to_s, 16);
        check("silent_fail", fail_s, 16);
        check("silent_pass", pass_s, 0);
        check("silent_ffv", ffv_s, 1);
        check("silent_first_fail", ff_s, 16'h0000);
        check("silent_drives", drv_s, 16);
        check("silent_drive_min", min_s, 16);
        check("silent_drive_max", max_s, 16);
    endtask

    initial begin
        logic [15:0] a;
        bit          good;
        tbl[0] = '{0, 3, 32'd4096, 32'd0,    16'h0000, 1'b0};
        tbl[1] = '{1, 0, 32'd330,  32'd3766, 16'h0010, 1'b1};
        tbl[2] = '{2, 0, 32'd1,    32'd4095, 16'h0001, 1'b1};

        for (int v = 0; v < N; v++) begin
            lat_tab[v] = int'($urandom_range(0, 2));
            flt_tab[v] = int'($urandom_range(0, 7));
        end
        exp_pass_r = 0;
        exp_ffv_r  = 1'b0;
        exp_ff_r   = 16'h0;
        for (int v = 0; v < N; v++) begin
            a = {4'((v >> 9) & 7), 4'((v >> 6) & 7),
                 4'((v >> 3) & 7), 4'(v & 7)};
            good = (flt_tab[v] == 6) ? nondecr(a) : (flt_tab[v] < 6);
            if (good) begin
                exp_pass_r++;
            end else if (!exp_ffv_r) begin
                exp_ffv_r = 1'b1;
                exp_ff_r  = a;
            end
        end

        repeat (3) @(posedge clock);
        #1;
        check("reset_enable", bus_m.enable_out, 0);
        check("reset_busy", busy_m, 0);
        check("reset_done", done_m, 0);
        check("reset_pass", pass_m, 0);
        check("reset_fail", fail_m, 0);
        check("reset_timeouts", to_m, 0);
        check("reset_ffv", ffv_m, 0);
        check("reset_array", bus_m.array_out, 0);
        check("reset_hi_ind", bus_m.hi_ind, 3);
        check("reset_lo_ind", bus_m.lo_ind, 0);
        reset_m = 1'b1;
        reset_r = 1'b1;
        reset_s = 1'b1;
        @(posedge clock); #1;
        check("idle_busy", busy_m, 0);

        fork
            begin
                run_main_table();
                run_main_corners();
            end
            run_random();
            run_silent();
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
